// File: rtl/data_memory.sv
// Word-organised data memory: combinational reads, clocked writes, hardware zero-fill after reset, sticky fault trap.
// Optional access statistics counters are built when DMEM_STATS_EN is defined.
package data_memory_pkg;
    typedef enum logic {
        MEM_READ_EN  = 1'b0,
        MEM_WRITE_EN = 1'b1
    } mem_en_t;

    typedef struct packed {
        logic        mem_enable;
        mem_en_t     mem_en;
        logic [31:0] address;
        logic [31:0] data_in;
    } data_memory_interface_t;
endpackage

module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  data_memory_interface_t mem_sig,
    input  logic                   fault_clear,
    output logic [31:0]            mem_data_out,
    output logic                   mem_ready,
    output logic                   mem_fault,
    output logic [31:0]            fault_addr,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
);
    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  clr_idx_reg;
    logic [31:0]       fault_addr_reg;
    logic [31:0]       mem [DEPTH];

    logic              addr_ok;
    logic              legal_acc;
    logic              illegal_acc;
    logic              rd_hit;
    logic              wr_hit;
    logic [IDX_W-1:0]  word_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [31:0]       mem_wdata;

    assign word_idx    = mem_sig.address[ADDR_LSB +: IDX_W];
    assign addr_ok     = (mem_sig.address[1:0] == 2'b00) && (mem_sig.address < ADDR_LIMIT);
    assign legal_acc   = (state_reg == ST_READY) && mem_sig.mem_enable && addr_ok;
    assign illegal_acc = (state_reg == ST_READY) && mem_sig.mem_enable && !addr_ok;
    assign rd_hit      = legal_acc && (mem_sig.mem_en == MEM_READ_EN);
    assign wr_hit      = legal_acc && (mem_sig.mem_en == MEM_WRITE_EN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_CLEAR;
            clr_idx_reg    <= '0;
            fault_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_CLEAR)
                clr_idx_reg <= clr_idx_reg + IDX_W'(1);
            // The first illegal address is kept; later ones in FAULT are not captured.
            if (illegal_acc)
                fault_addr_reg <= mem_sig.address;
            else if ((state_reg == ST_FAULT) && fault_clear)
                fault_addr_reg <= '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (clr_idx_reg == LAST_IDX) state_next = ST_READY;
            ST_READY: if (illegal_acc)             state_next = ST_FAULT;
            ST_FAULT: if (fault_clear)             state_next = ST_READY;
            default:                               state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        mem_ready    = (state_reg == ST_READY);
        mem_fault    = (state_reg == ST_FAULT);
        mem_data_out = legal_acc ? mem[word_idx] : '0;
    end

    // The zero-fill owns the write port while clearing; requests cannot reach it then.
    always_comb begin
        mem_we    = (state_reg == ST_CLEAR) || wr_hit;
        mem_widx  = (state_reg == ST_CLEAR) ? clr_idx_reg : word_idx;
        mem_wdata = (state_reg == ST_CLEAR) ? 32'd0 : mem_sig.data_in;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_widx] <= mem_wdata;
    end

    assign fault_addr = fault_addr_reg;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_reg;
    logic [31:0] wr_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            if (rd_hit && (rd_count_reg != 32'hFFFF_FFFF))
                rd_count_reg <= rd_count_reg + 32'd1;
            if (wr_hit && (wr_count_reg != 32'hFFFF_FFFF))
                wr_count_reg <= wr_count_reg + 32'd1;
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
